// File: rtl/cntr_modn_updn.sv
// Modulo-N up/down counter with enable, synchronous clear/load, wrap or
// saturate at the ends, terminal-count flag and registered wrap/load-error pulses.
module cntr_modn_updn #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             inc,
   input  logic             sat_mode,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
   localparam bit               FULL = (MODULUS == (1 << WIDTH));

   if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("cntr_modn_updn: illegal WIDTH/MODULUS combination");
   end

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;
   logic             r_load_err;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_wrap_nxt;
   logic             w_err_nxt;
   logic             w_din_ok;
   logic             w_oor;

   // With a full power-of-two modulus every encoding is legal, so the range
   // checks collapse to constants instead of comparing against an impossible bound.
   if (FULL) begin : g_full
      assign w_din_ok = 1'b1;
      assign w_oor    = 1'b0;
   end else begin : g_part
      assign w_din_ok = (32'(d_in) < MODULUS);
      assign w_oor    = (32'(r_cnt) >= MODULUS);
   end

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      if (clr) begin
         w_cnt_nxt = '0;
      end else if (load) begin
         if (w_din_ok) begin
            w_cnt_nxt = d_in;
         end else begin
            w_cnt_nxt = MAX;
            w_err_nxt = 1'b1;
         end
      end else if (en) begin
         if (w_oor) begin
            w_cnt_nxt = '0;
         end else if (inc) begin
            if (r_cnt == MAX) begin
               if (!sat_mode) begin
                  w_cnt_nxt  = '0;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end else begin
            if (r_cnt == '0) begin
               if (!sat_mode) begin
                  w_cnt_nxt  = MAX;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_wrap     <= w_wrap_nxt;
         r_load_err <= w_err_nxt;
      end
   end

   assign cnt      = r_cnt;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;
   assign tc       = en & ((inc & (r_cnt == MAX)) | (~inc & (r_cnt == '0)));

endmodule

// File: tb/tb_cntr_modn_updn.sv
// Directed bench for cntr_modn_updn: mod-3, mod-10 and full-range mod-4 instances
// share control inputs; each phase checks the instance it targets.
module tb_cntr_modn_updn;

   logic       clk = 1'b0;
   logic       reset_n, en, inc, sat_mode, clr, load;
   logic [3:0] d_in;
   logic [1:0] cnt3, cnt4;
   logic [3:0] cnt10;
   logic       tc3, wrap3, err3;
   logic       tc4, wrap4, err4;
   logic       tc10, wrap10, err10;

   int n_tests = 0;
   int n_fail  = 0;

   cntr_modn_updn #(.WIDTH(2), .MODULUS(3)) u3 (
      .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .sat_mode(sat_mode),
      .clr(clr), .load(load), .d_in(d_in[1:0]),
      .cnt(cnt3), .tc(tc3), .wrap(wrap3), .load_err(err3));

   cntr_modn_updn #(.WIDTH(4), .MODULUS(10)) u10 (
      .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .sat_mode(sat_mode),
      .clr(clr), .load(load), .d_in(d_in),
      .cnt(cnt10), .tc(tc10), .wrap(wrap10), .load_err(err10));

   cntr_modn_updn #(.WIDTH(2), .MODULUS(4)) u4 (
      .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .sat_mode(sat_mode),
      .clr(clr), .load(load), .d_in(d_in[1:0]),
      .cnt(cnt4), .tc(tc4), .wrap(wrap4), .load_err(err4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; inc = 1'b1; sat_mode = 1'b0;
      clr = 1'b0; load = 1'b0; d_in = '0;
      #1;
      chk("rst_cnt3", 32'(cnt3), 0);
      chk("rst_cnt10", 32'(cnt10), 0);
      chk("rst_wrap10", 32'(wrap10), 0);
      chk("rst_err10", 32'(err10), 0);
      tick(); tick();
      chk("rst_hold", 32'(cnt10), 0);
      reset_n = 1'b1;

      // mod-3 up, plus full-range mod-4 riding along
      en = 1'b1; inc = 1'b1; sat_mode = 1'b0;
      #1 chk("up3_tc0", 32'(tc3), 0);
      tick(); chk("up3_c1", 32'(cnt3), 1); chk("up3_w1", 32'(wrap3), 0);
      tick(); chk("up3_c2", 32'(cnt3), 2); chk("up3_tc2", 32'(tc3), 1);
      chk("up4_c2", 32'(cnt4), 2);
      tick(); chk("up3_c0", 32'(cnt3), 0); chk("up3_wrap", 32'(wrap3), 1);
      chk("up4_c3", 32'(cnt4), 3); chk("up4_tc3", 32'(tc4), 1);
      tick(); chk("up3_c1b", 32'(cnt3), 1); chk("up3_wrap_off", 32'(wrap3), 0);
      chk("up4_c0", 32'(cnt4), 0); chk("up4_wrap", 32'(wrap4), 1);

      // mod-3 down from 0
      clr = 1'b1; tick(); chk("clr3", 32'(cnt3), 0);
      clr = 1'b0; inc = 1'b0;
      #1 chk("dn3_tc0", 32'(tc3), 1);
      tick(); chk("dn3_c2", 32'(cnt3), 2); chk("dn3_w", 32'(wrap3), 1);
      chk("dn4_c3", 32'(cnt4), 3); chk("dn4_w", 32'(wrap4), 1);
      tick(); chk("dn3_c1", 32'(cnt3), 1); chk("dn3_w0", 32'(wrap3), 0);
      tick(); chk("dn3_c0", 32'(cnt3), 0);
      tick(); chk("dn3_c2b", 32'(cnt3), 2); chk("dn3_wb", 32'(wrap3), 1);

      // mod-10 saturate
      sat_mode = 1'b1; en = 1'b0; load = 1'b1; d_in = 4'd8;
      tick(); chk("sat_ld8", 32'(cnt10), 8); chk("sat_ld_err", 32'(err10), 0);
      load = 1'b0; en = 1'b1; inc = 1'b1;
      tick(); chk("sat_c9", 32'(cnt10), 9); chk("sat_tc", 32'(tc10), 1);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("sat_hold9", 32'(cnt10), 9); chk("sat_nowrap", 32'(wrap10), 0);
      end
      en = 1'b0; load = 1'b1; d_in = 4'd1;
      tick(); chk("sat_ld1", 32'(cnt10), 1);
      load = 1'b0; en = 1'b1; inc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("sat_hold0", 32'(cnt10), 0); chk("sat_nowrap0", 32'(wrap10), 0);
      end

      // out-of-range load, then wrap-mode up from 9
      sat_mode = 1'b0; en = 1'b0; load = 1'b1; d_in = 4'd12;
      tick(); chk("oor_cnt", 32'(cnt10), 9); chk("oor_err", 32'(err10), 1);
      load = 1'b0;
      tick(); chk("oor_err_off", 32'(err10), 0); chk("oor_hold", 32'(cnt10), 9);
      en = 1'b1; inc = 1'b1;
      tick(); chk("w10_c0", 32'(cnt10), 0); chk("w10_wrap", 32'(wrap10), 1);

      // priority: clr over load over en
      en = 1'b0; load = 1'b1; d_in = 4'd7;
      tick(); chk("pri_ld7", 32'(cnt10), 7);
      clr = 1'b1; load = 1'b1; en = 1'b1; d_in = 4'd5;
      tick(); chk("pri_clr", 32'(cnt10), 0); chk("pri_clr_w", 32'(wrap10), 0);
      chk("pri_clr_e", 32'(err10), 0);
      clr = 1'b0;
      tick(); chk("pri_ld5", 32'(cnt10), 5); chk("pri_ld5_e", 32'(err10), 0);

      // asynchronous reset mid-cycle
      load = 1'b0;
      tick(); chk("ar_c6", 32'(cnt10), 6);
      en = 1'b0;
      #2 reset_n = 1'b0;
      #1 chk("ar_cnt", 32'(cnt10), 0); chk("ar_wrap", 32'(wrap10), 0);
      chk("ar_err", 32'(err10), 0);
      #1 reset_n = 1'b1; en = 1'b1; inc = 1'b1;
      tick(); chk("ar_c1", 32'(cnt10), 1);
      tick(); chk("ar_c2", 32'(cnt10), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cntr_modn_updn.md
Name: cntr_modn_updn

Overview:
- Parametrised synchronous up/down counter with modulus N. It generalises the team's existing 3-state up/down counter next-state logic to any width and modulus.
- Adds enable, synchronous clear and load, a wrap/saturate mode, terminal-count detection and a registered wrap pulse.
- Used as the generic counter primitive in the practice-lab datapaths: timers, sequencers and modulo address generators.

Parameters:
- WIDTH, 4, counter register width in bits. Legal range is 2 to 16.
- MODULUS, 10, number of count states; the counter runs 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- inc  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  0 = wrap at the ends, 1 = saturate at the ends.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- d_in  input  WIDTH  load value.
- cnt  output  WIDTH  registered count value.
- tc  output  1  terminal count (combinational from cnt and inc).
- wrap  output  1  registered one-cycle pulse marking a wrap event.
- load_err  output  1  registered one-cycle pulse marking an out-of-range load.

Behaviour:
- Reset: reset_n low forces, asynchronously, cnt=0, wrap=0, load_err=0. These outputs hold until the first rising clk edge after reset_n goes high.
- All updates happen on the rising clk edge. Operation priority, highest first: clr, load, en. When none is active, cnt holds.
- clr=1:
  - cnt becomes 0; wrap=0; load_err=0.
  - load, en and d_in are ignored.
- load=1 (clr=0):
  - d_in < MODULUS: cnt becomes d_in and load_err=0.
  - d_in >= MODULUS: cnt becomes MODULUS-1 and load_err=1 for that one cycle.
  - wrap=0 in both cases. en is ignored.
- en=1 (clr=0, load=0), wrap mode (sat_mode=0):
  - Up: cnt==MODULUS-1 goes to 0 and sets wrap=1; otherwise cnt+1.
  - Down: cnt==0 goes to MODULUS-1 and sets wrap=1; otherwise cnt-1.
- en=1 (clr=0, load=0), saturate mode (sat_mode=1):
  - Up at MODULUS-1 holds; down at 0 holds.
  - wrap=0.
- wrap and load_err are 0 on every cycle not described above. Each is a single-cycle pulse and is never sticky.
- tc = en & ((inc & cnt==MODULUS-1) | (~inc & cnt==0)). It is combinational, and is valid in the cycle before the edge that would wrap or saturate.
- Direction and sat_mode may change on any cycle. Only their values at the clock edge matter.
- Out-of-range state: cnt cannot leave 0..MODULUS-1 through any input sequence. Next-state logic must still map any cnt >= MODULUS to 0 on an enabled count (defensive).
- Arithmetic is WIDTH bits unsigned with no intermediate overflow. When MODULUS == 2**WIDTH, wrap coincides with natural overflow and must still pulse wrap.
- Reset asserted mid-count takes effect immediately, independent of clk. The first edge after release behaves as if cnt=0.
- Illegal parameters (MODULUS<2 or MODULUS>2**WIDTH) must be caught by an elaboration-time check that stops compilation.

Test Plan:
- MODULUS=3, WIDTH=2, en=1, inc=1, sat_mode=0 from reset -> cnt sequence 0,1,2,0,1. wrap=1 only in the cycle cnt returns to 0. tc=1 while cnt=2. This matches the legacy 3-state counter going up.
- Same configuration with inc=0 from cnt=0 -> cnt 2,1,0,2. wrap=1 on each 0->2 transition. This matches the legacy counter going down.
- MODULUS=10, WIDTH=4, sat_mode=1, load d_in=8, then en=1, inc=1 for 4 cycles -> cnt 8,9,9,9,9 with wrap=0 throughout. Then inc=0 from cnt=1 for 3 cycles -> cnt 0,0,0.
- MODULUS=10, load d_in=12 -> cnt=9, load_err=1 for exactly one cycle, then 0.
- Simultaneous clr=1, load=1 with d_in=5, en=1 at cnt=7 -> cnt=0 and no pulses. Next, load=1 and en=1 with d_in=5 -> cnt=5 with no count that cycle.
- Count to cnt=6, then pulse reset_n low between clock edges -> cnt=0, wrap=0 and load_err=0 immediately. After release with en=1, inc=1 -> cnt 1,2,...
